// File: rtl/pipe_pkg.sv
// Shared pipeline types and defaults for the front end: fetch FSM states and PC constants.
package pipe_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, one-entry hold buffer, redirect/flush handling.
// Latency ack -> if_valid is one cycle; stall freezes IF outputs and parks an in-flight word in the hold buffer.
module if_fetch_unit
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        flush
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_d;
    logic [31:0]  addr_d;
    logic         valid_d;
    logic [31:0]  ipc_d, instr_d;
    logic         flush_d;
    logic [31:0]  hold_pc_q, hold_pc_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic [31:0]  target;
    logic [31:0]  pc_inc;
    logic         ack_seen;

    assign target   = redirect_target & 32'hFFFF_FFFC;
    assign pc_inc   = pc_q + PC_STEP;
    assign ack_seen = imem_req && imem_ack;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_d        = imem_req;
        addr_d       = imem_addr;
        valid_d      = if_valid;
        ipc_d        = if_pc;
        instr_d      = if_instr;
        flush_d      = 1'b0;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;

        if (redirect_valid) begin
            // An unacked request cannot be withdrawn, so it is drained before refetching.
            pc_d    = target;
            valid_d = 1'b0;
            flush_d = 1'b1;
            if (imem_req && !imem_ack) begin
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = target;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (ack_seen) begin
                        pc_d = pc_inc;
                        if (stall) begin
                            hold_pc_d    = pc_q;
                            hold_instr_d = imem_rdata;
                            req_d        = 1'b0;
                            state_d      = HOLD;
                        end else begin
                            valid_d = 1'b1;
                            ipc_d   = pc_q;
                            instr_d = imem_rdata;
                            req_d   = 1'b1;
                            addr_d  = pc_inc;
                        end
                    end else begin
                        req_d  = 1'b1;
                        addr_d = pc_q;
                        if (!stall) begin
                            valid_d = 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        valid_d = 1'b1;
                        ipc_d   = hold_pc_q;
                        instr_d = hold_instr_q;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        addr_d  = pc_q;
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                    req_d   = 1'b0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            imem_req     <= 1'b0;
            imem_addr    <= 32'h0;
            if_valid     <= 1'b0;
            if_pc        <= 32'h0;
            if_instr     <= 32'h0;
            flush        <= 1'b0;
            hold_pc_q    <= 32'h0;
            hold_instr_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            imem_req     <= req_d;
            imem_addr    <= addr_d;
            if_valid     <= valid_d;
            if_pc        <= ipc_d;
            if_instr     <= instr_d;
            flush        <= flush_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed pipeline scenarios plus randomized traffic against a transaction-level model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .flush           (flush)
    );

    // Reference: what is being asked of memory, what decode sees, and a parked word (if any).
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } word_t;

    logic        m_req;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    logic        m_vld;
    logic [31:0] m_ipc;
    logic [31:0] m_instr;
    logic        m_flush;
    logic        m_drain;
    word_t       held[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req   = 1'b0;
        m_addr  = 32'h0;
        m_pc    = 32'h0;
        m_vld   = 1'b0;
        m_ipc   = 32'h0;
        m_instr = 32'h0;
        m_flush = 1'b0;
        m_drain = 1'b0;
        held.delete();
    endtask

    task automatic model_step(input logic rv, input logic [31:0] tgt, input logic st,
                              input logic ak, input logic [31:0] rd);
        logic  done;
        word_t w;
        done    = m_req && ak;
        m_flush = 1'b0;
        if (rv) begin
            m_pc    = {tgt[31:2], 2'b00};
            m_vld   = 1'b0;
            m_flush = 1'b1;
            held.delete();
            m_drain = m_req && !ak;
            if (!m_drain) begin
                m_req  = 1'b1;
                m_addr = m_pc;
            end
        end else if (m_drain) begin
            if (ak) begin
                m_drain = 1'b0;
                m_addr  = m_pc;
            end
        end else if (held.size() != 0) begin
            if (!st) begin
                w       = held.pop_front();
                m_vld   = 1'b1;
                m_ipc   = w.pc;
                m_instr = w.instr;
                m_req   = 1'b1;
                m_addr  = m_pc;
            end
        end else if (done) begin
            m_pc = m_addr + 32'd4;
            if (st) begin
                held.push_back('{pc: m_addr, instr: rd});
                m_req = 1'b0;
            end else begin
                m_vld   = 1'b1;
                m_ipc   = m_addr;
                m_instr = rd;
                m_addr  = m_pc;
            end
        end else begin
            m_req  = 1'b1;
            m_addr = m_pc;
            if (!st) m_vld = 1'b0;
        end
    endtask

    task automatic check_outputs();
        chk("imem_req", 32'(imem_req), 32'(m_req));
        if (m_req) chk("imem_addr", imem_addr, m_addr);
        chk("flush", 32'(flush), 32'(m_flush));
        chk("if_valid", 32'(if_valid), 32'(m_vld));
        if (m_vld) begin
            chk("if_pc", if_pc, m_ipc);
            chk("if_instr", if_instr, m_instr);
        end
    endtask

    // Called at a falling edge; checks outputs, applies inputs for the next rising edge.
    task automatic step(input logic rv, input logic [31:0] tgt, input logic st,
                        input logic ak, input logic [31:0] rd);
        check_outputs();
        redirect_valid  = rv;
        redirect_target = tgt;
        stall           = st;
        imem_ack        = ak;
        imem_rdata      = rd;
        model_step(rv, tgt, st, ak, rd);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drops reset mid-cycle so the asynchronous clear is observed before any clock edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        imem_ack       = 1'b0;
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic        rv, st, ak;
        logic [31:0] tgt;

        do_reset();

        // Sequential fetch with ack every cycle.
        step(0, 0, 0, 0, $urandom);
        chk("first_req", 32'(imem_req), 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        step(0, 0, 0, 1, 32'h1111_0000);
        chk("seq_valid", 32'(if_valid), 32'h1);
        chk("seq_pc0", if_pc, 32'h0);
        step(0, 0, 0, 1, 32'h1111_0004);
        chk("seq_pc4", if_pc, 32'h4);

        // Stall arrives with the ack for pc=8.
        step(0, 0, 1, 1, 32'h1111_0008);
        chk("stall_hold_pc", if_pc, 32'h4);
        chk("stall_req_low", 32'(imem_req), 32'h0);
        step(0, 0, 1, 0, $urandom);
        step(0, 0, 1, 0, $urandom);
        chk("stall_hold_pc3", if_pc, 32'h4);
        step(0, 0, 0, 0, $urandom);
        chk("unstall_pc8", if_pc, 32'h8);
        chk("unstall_addr12", imem_addr, 32'hC);

        // Redirect with the fetch of 12 still outstanding.
        step(1, 32'h0000_0103, 0, 0, $urandom);
        chk("redir_flush", 32'(flush), 32'h1);
        chk("redir_old_addr", imem_addr, 32'hC);
        step(0, 0, 0, 0, $urandom);
        chk("redir_flush_once", 32'(flush), 32'h0);
        step(0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("drain_no_valid", 32'(if_valid), 32'h0);
        chk("drain_new_addr", imem_addr, 32'h0000_0100);
        step(0, 0, 0, 1, 32'h2222_0100);
        chk("after_drain_pc", if_pc, 32'h0000_0100);

        // Redirect coinciding with ack and stall.
        step(1, 32'h0000_0200, 1, 1, 32'hBAD0_BAD0);
        chk("redir_ack_valid", 32'(if_valid), 32'h0);
        chk("redir_ack_flush", 32'(flush), 32'h1);
        chk("redir_ack_addr", imem_addr, 32'h0000_0200);

        // Second redirect while draining.
        step(1, 32'h0000_0300, 0, 0, $urandom);
        step(1, 32'h0000_0405, 0, 0, $urandom);
        chk("drain_reflush", 32'(flush), 32'h1);
        step(0, 0, 0, 1, $urandom);
        chk("drain_latest_addr", imem_addr, 32'h0000_0404);

        // PC wrap at the top of the address space.
        step(1, 32'hFFFF_FFFC, 0, 1, $urandom);
        step(0, 0, 0, 1, 32'h3333_FFFC);
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset while parked in the hold buffer.
        step(0, 0, 1, 1, $urandom);
        chk("hold_req_low", 32'(imem_req), 32'h0);
        do_reset();
        step(0, 0, 0, 0, $urandom);
        chk("restart_addr", imem_addr, 32'h0);

        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            rv  = ($urandom_range(0, 9) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : $urandom;
            st  = ($urandom_range(0, 9) < 3);
            ak  = m_req && ($urandom_range(0, 9) < 6);
            step(rv, tgt, st, ak, $urandom);
        end
        check_outputs();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
